scroll_controller: RTL and testbench

Owns the character-memory write port and the first-row register on behalf of the command handler. It forwards the handler's character writes, and on a scroll request it advances the first displayed row and blanks the newly exposed bottom line. It sits between the command handler and the character memory / video timing. While it is busy it holds off the handler.

---
 rtl/vt52_pkg.sv | 29 ++
 rtl/row_blanker.sv | 50 +++++
 rtl/scroll_controller.sv | 149 ++++++++++++++
 tb/tb_scroll_controller.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vt52_pkg.sv
// Shared VT52 terminal definitions: screen geometry, fill byte, controller state encodings.
// Build option SCROLL_CONTROLLER_RESET_CLEAR_EN: reset blanks the whole character memory.
package vt52_pkg;

  localparam int ROWS = 16;
  localparam int COLS = 64;

  localparam logic [7:0] FILL_CHAR       = 8'h20;
  localparam logic [3:0] FIRST_ROW_RESET = 4'h0;

`ifdef SCROLL_CONTROLLER_RESET_CLEAR_EN
  localparam logic RESET_CLEAR = 1'b1;
`else
  localparam logic RESET_CLEAR = 1'b0;
`endif

  // One-hot, kept identical to the command handler's encoding
  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_SCROLL = 4'b0010,
    ST_ERASE  = 4'b0100,
    ST_CLEAR  = 4'b1000
  } state_t;

  function automatic logic [9:0] pack_addr(input logic [3:0] row, input logic [5:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/row_blanker.sv
// Column/address counter for blanking: one physical row (64 counts) or the full screen (1024 counts).
// Build option SCROLL_CONTROLLER_RESET_CLEAR_EN: counter comes out of reset in full-screen mode.
module row_blanker
  import vt52_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       full,
  input  logic [3:0] row,
  input  logic       step,
  output logic [9:0] address,
  output logic       done
);

  logic [9:0] cnt_r;
  logic [3:0] row_r;
  logic       full_r;

  // counter state: load on start, advance one count per issued write
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_r  <= 10'd0;
      row_r  <= 4'h0;
      full_r <= RESET_CLEAR;
    end else if (start) begin
      cnt_r  <= 10'd0;
      row_r  <= row;
      full_r <= full;
    end else if (step) begin
      cnt_r  <= cnt_r + 10'd1;
    end else begin
      cnt_r  <= cnt_r;
    end
  end

  // current address and last-count flag for the active mode
  always_comb begin
    address = pack_addr(row_r, cnt_r[5:0]);
    done    = (cnt_r[5:0] == 6'd63);
    if (full_r) begin
      address = cnt_r;
      done    = (cnt_r == 10'd1023);
    end else begin
      address = pack_addr(row_r, cnt_r[5:0]);
      done    = (cnt_r[5:0] == 6'd63);
    end
  end

endmodule

// File: rtl/scroll_controller.sv
// Character-memory write port owner: forwards handler writes, scrolls one line and blanks the exposed row.
// Build option SCROLL_CONTROLLER_RESET_CLEAR_EN: reset enters CLEAR and blanks all 1024 cells.
module scroll_controller
  import vt52_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       px_clk,
  input  logic [7:0] cmd_char,
  input  logic [9:0] cmd_address,
  input  logic       cmd_wen,
  input  logic       scroll_req,
  output logic       busy,
  output logic [7:0] new_char,
  output logic [9:0] new_char_address,
  output logic       new_char_wen,
  output logic [3:0] new_first_row,
  output logic       new_first_row_wen
);

  state_t     state_r, state_next;
  logic       pend_r, pend_d;
  logic       busy_d;
  logic [7:0] char_d;
  logic [9:0] addr_d;
  logic       wen_d;
  logic [3:0] first_row_d;
  logic       first_row_wen_d;
  logic       slot_s;
  logic       blank_start_s;
  logic       blank_step_s;
  logic [9:0] blank_addr_s;
  logic       blank_done_s;

  row_blanker u_blanker (
    .clk     (clk),
    .clr     (clr),
    .start   (blank_start_s),
    .full    (1'b0),
    .row     (new_first_row),
    .step    (blank_step_s),
    .address (blank_addr_s),
    .done    (blank_done_s)
  );

  // next state and next output values; strobes default low so px_clk=1 cycles clear them
  always_comb begin
    slot_s          = ~px_clk;
    state_next      = state_r;
    char_d          = new_char;
    addr_d          = new_char_address;
    wen_d           = 1'b0;
    first_row_d     = new_first_row;
    first_row_wen_d = 1'b0;
    blank_start_s   = 1'b0;
    blank_step_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        // a pending scroll makes the block busy, so handler writes are refused
        if (pend_r) begin
          state_next = ST_SCROLL;
        end else if (slot_s && cmd_wen) begin
          char_d = cmd_char;
          addr_d = cmd_address;
          wen_d  = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_SCROLL: begin
        if (slot_s) begin
          first_row_d     = new_first_row + 4'd1;
          first_row_wen_d = 1'b1;
          blank_start_s   = 1'b1;
          state_next      = ST_ERASE;
        end else begin
          state_next = ST_SCROLL;
        end
      end
      ST_ERASE: begin
        if (slot_s) begin
          char_d       = FILL_CHAR;
          addr_d       = blank_addr_s;
          wen_d        = 1'b1;
          blank_step_s = 1'b1;
          if (blank_done_s) begin
            state_next = pend_r ? ST_SCROLL : ST_IDLE;
          end else begin
            state_next = ST_ERASE;
          end
        end else begin
          state_next = ST_ERASE;
        end
      end
      ST_CLEAR: begin
        if (slot_s) begin
          char_d       = FILL_CHAR;
          addr_d       = blank_addr_s;
          wen_d        = 1'b1;
          blank_step_s = 1'b1;
          if (blank_done_s) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_CLEAR;
          end
        end else begin
          state_next = ST_CLEAR;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // entering SCROLL consumes the request; a request landing on that edge finds pend set and is dropped
    if ((state_next == ST_SCROLL) && (state_r != ST_SCROLL)) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_r | scroll_req;
    end

    busy_d = (state_next != ST_IDLE) | pend_d;
  end

  // state, request flag and registered outputs
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r           <= RESET_CLEAR ? ST_CLEAR : ST_IDLE;
      pend_r            <= 1'b0;
      busy              <= RESET_CLEAR;
      new_char          <= 8'h00;
      new_char_address  <= 10'h000;
      new_char_wen      <= 1'b0;
      new_first_row     <= FIRST_ROW_RESET;
      new_first_row_wen <= 1'b0;
    end else begin
      state_r           <= state_next;
      pend_r            <= pend_d;
      busy              <= busy_d;
      new_char          <= char_d;
      new_char_address  <= addr_d;
      new_char_wen      <= wen_d;
      new_first_row     <= first_row_d;
      new_first_row_wen <= first_row_wen_d;
    end
  end

endmodule

// File: tb/tb_scroll_controller.sv
// Scoreboard bench for scroll_controller: expected memory writes and first-row updates are queued
// as stimulus is driven and checked in order as the DUT strobes them.
module tb_scroll_controller;

  logic       clk;
  logic       clr;
  logic       px_clk;
  logic [7:0] cmd_char;
  logic [9:0] cmd_address;
  logic       cmd_wen;
  logic       scroll_req;
  logic       busy;
  logic [7:0] new_char;
  logic [9:0] new_char_address;
  logic       new_char_wen;
  logic [3:0] new_first_row;
  logic       new_first_row_wen;

  scroll_controller dut (
    .clk               (clk),
    .clr               (clr),
    .px_clk            (px_clk),
    .cmd_char          (cmd_char),
    .cmd_address       (cmd_address),
    .cmd_wen           (cmd_wen),
    .scroll_req        (scroll_req),
    .busy              (busy),
    .new_char          (new_char),
    .new_char_address  (new_char_address),
    .new_char_wen      (new_char_wen),
    .new_first_row     (new_first_row),
    .new_first_row_wen (new_first_row_wen)
  );

  typedef struct {
    bit         is_fr;
    logic [9:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] model_fr = 4'h0;
  logic       prev_wen = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // clk period 10; px_clk toggles on each falling edge so it alternates per clk cycle
  initial begin
    clk    = 1'b0;
    px_clk = 1'b0;
    forever begin
      #5 clk = 1'b1;
      #5 clk = 1'b0;
      px_clk = ~px_clk;
    end
  end

  // output monitor: pops one scoreboard entry per strobe
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (new_first_row_wen) begin
        if (sb.size() == 0) begin
          check("fr_unexpected", 32'(new_first_row_wen), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("fr_kind", 32'(mon_e.is_fr), 32'd1);
          check("first_row", 32'(new_first_row), 32'(mon_e.data));
        end
      end
      if (new_char_wen) begin
        check("wen_pulse", 32'(prev_wen), 32'd0);
        if (sb.size() == 0) begin
          check("wr_unexpected", 32'(new_char_address), 32'h7fff_ffff);
        end else begin
          mon_e = sb.pop_front();
          check("wr_kind", 32'(mon_e.is_fr), 32'd0);
          check("wr_addr", 32'(new_char_address), 32'(mon_e.addr));
          check("wr_char", 32'(new_char), 32'(mon_e.data));
        end
      end
      prev_wen = new_char_wen;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // leaves the bench just before a posedge whose cycle is a write slot
  task automatic slot_sync();
    step();
    while (px_clk !== 1'b0) step();
  endtask

  task automatic push_wr(input logic [9:0] a, input logic [7:0] d);
    exp_t e;
    e.is_fr = 1'b0;
    e.addr  = a;
    e.data  = d;
    sb.push_back(e);
  endtask

  task automatic push_scroll(input int ncols);
    exp_t       e;
    logic [3:0] old_row;
    old_row  = model_fr;
    model_fr = model_fr + 4'd1;
    e.is_fr  = 1'b1;
    e.addr   = 10'h000;
    e.data   = {4'h0, model_fr};
    sb.push_back(e);
    for (int c = 0; c < ncols; c++) push_wr({old_row, 6'(c)}, 8'h20);
  endtask

  task automatic wait_idle(input string tag, input int expect_n);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 600) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, 32'(n), 32'(expect_n));
  endtask

  task automatic release_reset();
    int n;
    clr = 1'b0;
`ifdef SCROLL_CONTROLLER_RESET_CLEAR_EN
    for (int i = 0; i < 1024; i++) push_wr(10'(i), 8'h20);
    cmd_wen     = 1'b1;
    cmd_char    = 8'h55;
    cmd_address = 10'h2AA;
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    cmd_wen = 1'b0;
    check("clear_busy_len", 32'(n >= 2046 && n <= 2050), 32'd1);
`else
    n = 0;
    step();
    check("idle_after_reset", 32'(busy), 32'(n));
`endif
  endtask

  initial begin
    int  n;
    bit  found;
    clr         = 1'b1;
    cmd_char    = 8'h00;
    cmd_address = 10'h000;
    cmd_wen     = 1'b0;
    scroll_req  = 1'b0;
    repeat (3) step();
    check("rst_wen", 32'(new_char_wen), 32'd0);
    check("rst_char", 32'(new_char), 32'd0);
    check("rst_addr", 32'(new_char_address), 32'd0);
    check("rst_first_row", 32'(new_first_row), 32'd0);
    check("rst_fr_wen", 32'(new_first_row_wen), 32'd0);
`ifdef SCROLL_CONTROLLER_RESET_CLEAR_EN
    check("rst_busy", 32'(busy), 32'd1);
`else
    check("rst_busy", 32'(busy), 32'd0);
`endif
    release_reset();

    // handler write forwarded with 1-clk latency, cleared the cycle after
    slot_sync();
    cmd_char    = 8'h41;
    cmd_address = 10'h085;
    cmd_wen     = 1'b1;
    push_wr(10'h085, 8'h41);
    @(posedge clk);
    #1;
    cmd_wen = 1'b0;
    check("fwd_wen_hi", 32'(new_char_wen), 32'd1);
    @(posedge clk);
    #1;
    check("fwd_wen_lo", 32'(new_char_wen), 32'd0);

    // cmd_wen only during a px_clk=1 cycle is not a write slot
    step();
    while (px_clk !== 1'b1) step();
    cmd_address = 10'h3FF;
    cmd_wen     = 1'b1;
    @(posedge clk);
    #1;
    cmd_wen = 1'b0;
    check("no_slot_wen", 32'(new_char_wen), 32'd0);

    // 16 scrolls: first erases row 0 (000..03F), last wraps 15 -> 0 erasing 3C0..3FF
    for (int s = 0; s < 16; s++) begin
      slot_sync();
      scroll_req = 1'b1;
      push_scroll(64);
      @(posedge clk);
      #1;
      scroll_req = 1'b0;
      check("req_busy", 32'(busy), 32'd1);
      wait_idle("scroll_len", 130);
    end
    check("wrap_first_row", 32'(new_first_row), 32'd0);

    // handler write and scroll request in the same slot: write first, then the scroll
    slot_sync();
    scroll_req  = 1'b1;
    cmd_wen     = 1'b1;
    cmd_char    = 8'h5A;
    cmd_address = 10'h1C3;
    push_wr(10'h1C3, 8'h5A);
    push_scroll(64);
    @(posedge clk);
    #1;
    scroll_req = 1'b0;
    cmd_wen    = 1'b0;
    check("coll_wen", 32'(new_char_wen), 32'd1);
    wait_idle("coll_len", 130);

    // three requests during one erase collapse into one extra scroll; busy writes are dropped
    slot_sync();
    scroll_req = 1'b1;
    push_scroll(64);
    push_scroll(64);
    @(posedge clk);
    #1;
    scroll_req = 1'b0;
    for (int r = 0; r < 3; r++) begin
      repeat (15) step();
      scroll_req = 1'b1;
      step();
      scroll_req = 1'b0;
    end
    slot_sync();
    cmd_wen     = 1'b1;
    cmd_char    = 8'h7E;
    cmd_address = 10'h155;
    step();
    cmd_wen = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 600) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("double_len", 32'(n > 200 && n < 300), 32'd1);
    check("double_first_row", 32'(new_first_row), 32'(model_fr));

    // reset in the middle of an erase, right after the col=20 write
    slot_sync();
    scroll_req = 1'b1;
    push_scroll(21);
    @(posedge clk);
    #1;
    scroll_req = 1'b0;
    found = 1'b0;
    n = 0;
    while (!found && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (new_char_wen === 1'b1 && new_char_address[5:0] == 6'd20) found = 1'b1;
    end
    check("col20_seen", 32'(found), 32'd1);
    clr = 1'b1;
    model_fr = 4'h0;
    @(posedge clk);
    #1;
    check("abort_wen", 32'(new_char_wen), 32'd0);
    check("abort_first_row", 32'(new_first_row), 32'd0);
`ifdef SCROLL_CONTROLLER_RESET_CLEAR_EN
    check("abort_busy", 32'(busy), 32'd1);
`else
    check("abort_busy", 32'(busy), 32'd0);
`endif
    step();
    release_reset();

    repeat (6) step();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
